// File: rtl/sam_pkg.sv
// Shared definitions for the sam memory command arbiter slice.
// Contents:
//   sam_op_t    : command opcode carried in bits [OP_MSB:OP_LSB] of a beat
//   OP_*/ADDR_* : command word field positions
//   arb_state_t : arbiter grant state
package sam_pkg;

  typedef enum logic [1:0] {
    OP_STORE = 2'b00,
    OP_LOAD  = 2'b01
  } sam_op_t;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 30;
  localparam int unsigned ADDR_MSB = 29;
  localparam int unsigned ADDR_LSB = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } arb_state_t;

endpackage

// File: rtl/sam_tag_fifo.sv
// 1-bit wide tag FIFO recording which requester owns each outstanding load.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   push, din   : write request and requester id (ignored while full)
//   pop         : read request (ignored while empty)
//   dout        : id at the head of the FIFO
//   full, empty : occupancy flags
module sam_tag_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  import sam_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are power-of-two wide, so the increment wraps on its own.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sam_mem_arbiter.sv
// Two-requester command arbiter and load-response router for sam_wrapper.
// Round-robin, packet-atomic grants share the memory command stream; each
// load response is steered back to its issuer in order via a tag FIFO.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   s0_*, s1_*           : requester command streams (data/valid/last/ready)
//   m_*                  : command stream to memory
//   r_*                  : response stream from memory
//   d0_*, d1_*           : response streams to requesters
//   busy                 : grant active or loads outstanding
//   orphan               : one-cycle pulse per dropped response beat
//   gnt_cnt0/1, load_cnt : saturating statistics, present only when
//                          SAM_ARB_STATS_EN is defined
module sam_mem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_DEPTH = 8,
  parameter logic [1:0]  OP_LOAD   = 2'b01
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_valid,
  input  logic              r_last,
  output logic              r_ready,
  output logic [DATA_W-1:0] d0_data,
  output logic              d0_valid,
  output logic              d0_last,
  input  logic              d0_ready,
  output logic [DATA_W-1:0] d1_data,
  output logic              d1_valid,
  output logic              d1_last,
  input  logic              d1_ready,
  output logic              busy,
  output logic              orphan
`ifdef SAM_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       load_cnt
`endif
);
  import sam_pkg::*;

  arb_state_t        state;
  logic              rr_last;   // requester granted most recently
  logic              orphan_q;
  logic [DATA_W-1:0] cur_data;
  logic              cur_valid;
  logic              cur_last;
  logic              sel;
  logic              stall;
  logic              is_load;
  logic              accept;
  logic              push;
  logic              pop;
  logic              grant0;
  logic              grant1;
  logic              tag_full;
  logic              tag_empty;
  logic              tag_head;

  always_comb begin
    sel       = (state == GRANT1);
    cur_data  = sel ? s1_data  : s0_data;
    cur_valid = sel ? s1_valid : s0_valid;
    cur_last  = sel ? s1_last  : s0_last;
    is_load   = (cur_data[OP_MSB:OP_LSB] == OP_LOAD);
    stall     = is_load & tag_full;

    m_data    = cur_data;
    m_last    = cur_last;
    m_valid   = (state != IDLE) & cur_valid & ~stall;
    s0_ready  = (state == GRANT0) & m_ready & ~stall;
    s1_ready  = (state == GRANT1) & m_ready & ~stall;
    accept    = m_valid & m_ready;
    push      = accept & is_load;

    // Contention goes to whoever was not granted last.
    grant0    = (state == IDLE) & s0_valid & (~s1_valid | rr_last);
    grant1    = (state == IDLE) & s1_valid & (~s0_valid | ~rr_last);

    d0_data   = r_data;
    d1_data   = r_data;
    d0_last   = r_last;
    d1_last   = r_last;
    if (tag_empty) begin
      // Nobody is waiting: sink the beat so the memory never blocks.
      r_ready  = 1'b1;
      d0_valid = 1'b0;
      d1_valid = 1'b0;
    end else begin
      d0_valid = r_valid & ~tag_head;
      d1_valid = r_valid & tag_head;
      r_ready  = tag_head ? d1_ready : d0_ready;
    end
    pop       = ~tag_empty & r_valid & r_ready & r_last;

    busy      = (state != IDLE) | ~tag_empty;
    orphan    = orphan_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      orphan_q <= 1'b0;
    end else begin
      orphan_q <= tag_empty & r_valid;
      case (state)
        IDLE: begin
          if (grant0)      state <= GRANT0;
          else if (grant1) state <= GRANT1;
        end
        GRANT0, GRANT1: begin
          if (accept & cur_last) begin
            state   <= IDLE;
            rr_last <= sel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sam_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .din  (sel),
    .pop  (pop),
    .dout (tag_head),
    .full (tag_full),
    .empty(tag_empty)
  );

`ifdef SAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
      load_cnt <= '0;
    end else begin
      if (grant0 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (grant1 && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 16'd1;
      if (push   && load_cnt != '1) load_cnt <= load_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sam_mem_arbiter.sv
// Scoreboard bench for sam_mem_arbiter: stimulus queues per requester, a
// memory responder, and a negedge monitor holding a queue-based model of
// grants, outstanding load owners and orphan pulses.
module tb_sam_mem_arbiter;
  localparam int unsigned TAG_DEPTH = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] s0_data, s1_data, m_data, r_data, d0_data, d1_data;
  logic        s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic        m_valid, m_last, m_ready, r_valid, r_last, r_ready;
  logic        d0_valid, d0_last, d0_ready, d1_valid, d1_last, d1_ready;
  logic        busy, orphan;
`ifdef SAM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, load_cnt;
`endif

  always #5 clk = ~clk;

  sam_mem_arbiter #(
    .DATA_W   (32),
    .TAG_DEPTH(TAG_DEPTH),
    .OP_LOAD  (2'b01)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .r_data(r_data), .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready),
    .d0_data(d0_data), .d0_valid(d0_valid), .d0_last(d0_last), .d0_ready(d0_ready),
    .d1_data(d1_data), .d1_valid(d1_valid), .d1_last(d1_last), .d1_ready(d1_ready),
    .busy(busy), .orphan(orphan)
`ifdef SAM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .load_cnt(load_cnt)
`endif
  );

  int    tests = 0;
  int    fails = 0;
  beat_t sq0[$], sq1[$];           // stimulus = expected command beats
  int    pkts_pushed = 0;
  bit    rnd_en = 1'b0, d1_hold = 1'b0, mem_hold = 1'b0;
  int    orphan_req = 0;

  // Monitor-owned model state
  int    cyc = 0, pkts_done = 0, loads_issued = 0, orphan_cnt = 0;
  int    gnt0 = 0, gnt1 = 0;
  bit    open = 1'b0, owner = 1'b0, last_owner = 1'b1, orph_exp = 1'b0;
  bit    tagq[$];                  // owners of outstanding loads, issue order
  int    mi0 = 0, mi1 = 0;
  int    acc_cyc[$], pop_cyc[$];
  bit    own_hist[$], dest_hist[$];

  int    served = 0;               // responder-owned

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_beat(input bit s, input logic [31:0] d, input bit l);
    beat_t b;
    b.data = d;
    b.last = l;
    if (s) sq1.push_back(b);
    else   sq0.push_back(b);
    if (l) pkts_pushed++;
  endfunction

  // Requester drivers
  initial begin : drv0
    bit f;
    int i;
    i = 0;
    s0_valid = 0; s0_data = '0; s0_last = 0;
    forever begin
      @(negedge clk); f = s0_valid && s0_ready;
      @(posedge clk); #1;
      if (f) i++;
      s0_valid = (i < sq0.size());
      if (s0_valid) begin s0_data = sq0[i].data; s0_last = sq0[i].last; end
    end
  end

  initial begin : drv1
    bit f;
    int i;
    i = 0;
    s1_valid = 0; s1_data = '0; s1_last = 0;
    forever begin
      @(negedge clk); f = s1_valid && s1_ready;
      @(posedge clk); #1;
      if (f) i++;
      s1_valid = (i < sq1.size());
      if (s1_valid) begin s1_data = sq1[i].data; s1_last = sq1[i].last; end
    end
  end

  // Ready drivers
  initial begin : rdy
    m_ready = 1; d0_ready = 1; d1_ready = 1;
    forever begin
      @(posedge clk); #1;
      m_ready  = !rnd_en || ($urandom_range(0, 3) != 0);
      d0_ready = !rnd_en || ($urandom_range(0, 3) != 0);
      d1_ready = !d1_hold && (!rnd_en || ($urandom_range(0, 3) != 0));
    end
  end

  // Memory responder: one 1-2 beat response per issued load, plus injected orphans
  initial begin : mem
    bit f;
    int odone;
    odone = 0;
    r_valid = 0; r_data = '0; r_last = 0;
    forever begin
      @(negedge clk); f = r_valid && r_ready;
      @(posedge clk); #1;
      if (f) begin
        if (r_last) r_valid = 0;
        else begin r_data = $urandom; r_last = 1; end
      end
      if (!r_valid && rstn) begin
        if (odone != orphan_req) begin
          r_valid = 1; r_last = 1; r_data = $urandom; odone++;
        end else if (!mem_hold && served < loads_issued && $urandom_range(0, 2) != 0) begin
          served++; r_valid = 1; r_last = ($urandom_range(0, 1) == 1); r_data = $urandom;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    bit          hd, cv, stl, ok;
    logic [31:0] cd;
    beat_t       eb;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) continue;
      chk("busy", busy, open || tagq.size() != 0);
      if (!open) begin
        chk("m_valid_idle", m_valid, 0);
        chk("s0_ready_idle", s0_ready, 0);
        chk("s1_ready_idle", s1_ready, 0);
      end else begin
        cd  = owner ? s1_data : s0_data;
        cv  = owner ? s1_valid : s0_valid;
        stl = (cd[31:30] == 2'b01) && (tagq.size() == TAG_DEPTH);
        chk("m_valid", m_valid, cv && !stl);
        chk("owner_ready", owner ? s1_ready : s0_ready, m_ready && !stl);
        chk("other_ready", owner ? s0_ready : s1_ready, 0);
      end
      if (tagq.size() != 0) begin
        hd = tagq[0];
        chk("d_head_valid", hd ? d1_valid : d0_valid, r_valid);
        chk("d_other_valid", hd ? d0_valid : d1_valid, 0);
        chk("r_ready_routed", r_ready, hd ? d1_ready : d0_ready);
        if (r_valid) begin
          chk("d_data", hd ? d1_data : d0_data, r_data);
          chk("d_last", hd ? d1_last : d0_last, r_last);
        end
      end else begin
        chk("r_ready_empty", r_ready, 1);
        chk("d0_valid_empty", d0_valid, 0);
        chk("d1_valid_empty", d1_valid, 0);
      end
      chk("orphan", orphan, orph_exp);
      if (orphan) orphan_cnt++;
      orph_exp = (tagq.size() == 0) && r_valid;
      if (tagq.size() != 0 && r_valid && r_ready && r_last) begin
        dest_hist.push_back(tagq[0]);
        pop_cyc.push_back(cyc);
        void'(tagq.pop_front());
      end
      if (open) begin
        if (m_valid && m_ready) begin
          if (owner) begin ok = (mi1 < sq1.size()); if (ok) eb = sq1[mi1]; mi1++; end
          else       begin ok = (mi0 < sq0.size()); if (ok) eb = sq0[mi0]; mi0++; end
          chk("m_beat_expected", ok, 1);
          if (!ok) eb = {m_data, m_last};
          chk("m_data", m_data, eb.data);
          chk("m_last", m_last, eb.last);
          if (eb.data[31:30] == 2'b01) begin tagq.push_back(owner); loads_issued++; end
          acc_cyc.push_back(cyc);
          own_hist.push_back(owner);
          if (eb.last) begin open = 0; last_owner = owner; pkts_done++; end
        end
      end else if (s0_valid || s1_valid) begin
        owner = (s0_valid && s1_valid) ? !last_owner : s1_valid;
        open  = 1;
        if (owner) gnt1++; else gnt0++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int t = 0;
    while (pkts_done < n && t < budget) begin @(negedge clk); t++; end
    chk("wait_pkts_timeout", pkts_done >= n, 1);
  endtask

  task automatic wait_quiet(input int budget);
    int t = 0;
    while (!(pkts_done == pkts_pushed && tagq.size() == 0 && served == loads_issued && !r_valid)
           && t < budget) begin
      @(negedge clk); t++;
    end
    chk("wait_quiet_timeout", t < budget, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          na, np, nd, n0, no, t;
    logic [31:0] w;
    bit          s;
    int unsigned len;

    rstn = 0;
    wait_cyc(3);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_d0_valid", d0_valid, 0);
    chk("rst_d1_valid", d1_valid, 0);
    chk("rst_orphan", orphan, 0);
    chk("rst_busy", busy, 0);
    chk("rst_r_ready", r_ready, 1);

    // Contention from reset: single-beat stores on both requesters
    for (int i = 0; i < 4; i++) begin
      push_beat(0, {2'b00, 14'(i), 16'h1000 + 16'(i)}, 1);
      push_beat(1, {2'b00, 14'(i), 16'h2000 + 16'(i)}, 1);
    end
    @(posedge clk); #1 rstn = 1;
    wait_pkts(8, 100);
    for (int i = 0; i < 8; i++) chk("cont_order", own_hist[i], i % 2);
    for (int i = 1; i < 8; i++) chk("cont_spacing", acc_cyc[i] - acc_cyc[i-1], 2);

    // Single requester: store then load from s0
    nd = dest_hist.size();
    push_beat(0, {2'b00, 14'd5, 16'hFEED}, 1);
    push_beat(0, {2'b01, 14'd5, 16'h0000}, 1);
    wait_quiet(200);
    chk("single_resp_count", dest_hist.size() - nd, 1);
    chk("single_resp_dest", dest_hist[nd], 0);

    // Ordering: s1 load then s0 load; d1 backpressure holds r_ready
    mem_hold = 1; d1_hold = 1; nd = dest_hist.size();
    push_beat(1, {2'b01, 14'd20, 16'h0000}, 1);
    wait_pkts(pkts_pushed, 50);
    push_beat(0, {2'b01, 14'd5, 16'h0000}, 1);
    wait_pkts(pkts_pushed, 50);
    mem_hold = 0;
    t = 0;
    while (!r_valid && t < 50) begin @(negedge clk); t++; end
    chk("ord_r_valid_seen", r_valid, 1);
    wait_cyc(5);
    chk("ord_r_ready_held", r_ready, 0);
    chk("ord_d0_valid_held", d0_valid, 0);
    chk("ord_no_resp_yet", dest_hist.size() - nd, 0);
    d1_hold = 0;
    wait_quiet(200);
    chk("ord_resp_count", dest_hist.size() - nd, 2);
    chk("ord_first_dest", dest_hist[nd], 1);
    chk("ord_second_dest", dest_hist[nd+1], 0);

    // Atomicity: 3-beat s0 packet with s1 waiting
    na = acc_cyc.size();
    push_beat(0, {2'b00, 14'd1, 16'hA001}, 0);
    push_beat(0, {2'b00, 14'd1, 16'hA002}, 0);
    push_beat(0, {2'b00, 14'd1, 16'hA003}, 1);
    wait_cyc(1);
    push_beat(1, {2'b00, 14'd2, 16'hB001}, 1);
    wait_quiet(100);
    chk("atom_beats", acc_cyc.size() - na, 4);
    chk("atom_s1_after", own_hist[na+3], 1);
    chk("atom_gap", acc_cyc[na+3] - acc_cyc[na+2], 2);

    // Tag full: nine loads with no responses returning
    mem_hold = 1; n0 = loads_issued; na = acc_cyc.size(); np = pop_cyc.size();
    for (int i = 0; i < 9; i++) push_beat(0, {2'b01, 14'(i + 100), 16'h0000}, 1);
    wait_cyc(30);
    chk("full_accepted", loads_issued - n0, 8);
    chk("full_m_valid", m_valid, 0);
    chk("full_s0_ready", s0_ready, 0);
    chk("full_busy", busy, 1);
    mem_hold = 0;
    wait_quiet(500);
    chk("full_all_accepted", loads_issued - n0, 9);
    chk("full_resume_cycle", acc_cyc[na+8], pop_cyc[np] + 1);

    // Orphan: response with nothing outstanding
    no = orphan_cnt;
    orphan_req++;
    wait_cyc(6);
    chk("orphan_pulses", orphan_cnt - no, 1);

    // Randomized traffic with random backpressure
    rnd_en = 1;
    for (int p = 0; p < 40; p++) begin
      s   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 3);
      for (int unsigned b = 0; b < len; b++) begin
        w = $urandom;
        w[31:30] = 2'($urandom_range(0, 3));
        push_beat(s, w, b == len - 1);
      end
      wait_cyc($urandom_range(0, 5));
    end
    wait_quiet(5000);
    rnd_en = 0;
    chk("rand_pkts_done", pkts_done, pkts_pushed);
    chk("rand_all_served", served, loads_issued);

`ifdef SAM_ARB_STATS_EN
    chk("stat_gnt0", gnt_cnt0, gnt0);
    chk("stat_gnt1", gnt_cnt1, gnt1);
    chk("stat_loads", load_cnt, loads_issued);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sam_mem_arbiter.md
# sam_mem_arbiter

Two-requester command arbiter and response router placed in front of `sam_wrapper`. It shares the single memory command stream between two packet sources with round-robin, packet-atomic grants. Each load response returned by the memory is steered back to the requester that issued the matching load, in issue order, using an internal tag FIFO.

## Interface
- `DATA_W`, 32, command/response word width
- `TAG_DEPTH`, 8, maximum outstanding loads (power of two, ≥2)
- `OP_LOAD`, 2'b01, opcode value in bits [31:30] that marks a beat as a load
---
- `clk` in 1: single clock, all logic rising-edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `s0_data` in DATA_W; `s0_valid` in 1; `s0_last` in 1; `s0_ready` out 1: requester 0 command stream.
- `s1_data` in DATA_W; `s1_valid` in 1; `s1_last` in 1; `s1_ready` out 1: requester 1 command stream.
- `m_data` out DATA_W; `m_valid` out 1; `m_last` out 1; `m_ready` in 1: drives memory `in_*`.
- `r_data` in DATA_W; `r_valid` in 1; `r_last` in 1; `r_ready` out 1: driven by memory `out_*`.
- `d0_data` out DATA_W; `d0_valid` out 1; `d0_last` out 1; `d0_ready` in 1: responses to requester 0.
- `d1_data` out DATA_W; `d1_valid` out 1; `d1_last` out 1; `d1_ready` in 1: responses to requester 1.
- `busy` out 1: state ≠ IDLE or tag FIFO non-empty.
- `orphan` out 1: one-cycle pulse when a response beat is dropped.

## Operation
- Beat accepted on an interface when valid & ready are both high in the same cycle.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE → GRANTx when only sx_valid is high.
  - IDLE, both valid: grant the requester not granted last. `rr_ptr` resets to prefer requester 0.
  - GRANTx → IDLE on an accepted beat with sx_last = 1; `rr_ptr` records x.
  - Otherwise stay in GRANTx. The grant is packet-atomic, with no preemption.
- In GRANTx:
  - `m_data`/`m_last` = sx_data/sx_last.
  - `m_valid` = sx_valid & !stall.
  - `sx_ready` = m_ready & !stall.
  - The other requester's ready is 0.
- stall = (sx_data[31:30] == OP_LOAD) & tag_full.
- Each accepted load beat pushes requester id x into the tag FIFO. Non-load beats push nothing; the memory returns no response for stores.
- Response routing with FIFO non-empty and head = y:
  - `dy_*` mirrors `r_*`, and `r_ready` = dy_ready.
  - The other d_valid is 0.
  - Pop on an accepted response beat with r_last = 1.
- Response routing with FIFO empty:
  - `r_ready` = 1 and both d_valid = 0.
  - Each accepted beat pulses `orphan` (registered, one cycle later).
- Push while full is never performed, even with a simultaneous pop.
- Simultaneous push and pop when not full: both take effect and count is unchanged.
- Tag pointers wrap modulo TAG_DEPTH.

## Timing
- Reset values:
  - State IDLE, `rr_ptr` prefers 0, FIFO empty.
  - `m_valid`, `s0_ready`, `s1_ready`, `d0_valid`, `d1_valid` = 0.
  - `orphan` = 0, `busy` = 0.
  - `r_ready` = 1, since the FIFO is empty.
- Grant latency: valid seen in IDLE at cycle t → GRANT from t+1. The first beat can be accepted at t+1.
- A last beat accepted at cycle t gives IDLE at t+1, and the next grant takes effect at t+2. Single-beat packets sustain one beat per 2 cycles.
- Command and response data paths are combinational, with zero added latency. Only the FSM, FIFO, `rr_ptr` and `orphan` are registered.
- Reset mid-packet: returns to IDLE immediately, and outstanding tags are discarded. Responses after reset are dropped as orphans.

## Configuration
- Macro: `SAM_ARB_STATS_EN`.
- Defined: adds the following outputs, all reset to 0 and saturating at 0xFFFF:
  - `gnt_cnt0` [15:0]: packets granted to requester 0.
  - `gnt_cnt1` [15:0]: packets granted to requester 1.
  - `load_cnt` [15:0]: load beats pushed.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- `sam_pkg` holds:
  - The opcode enum: OP_STORE = 2'b00, OP_LOAD = 2'b01.
  - Field constants: OP_MSB = 31, OP_LSB = 30, ADDR_MSB = 29, ADDR_LSB = 16.
  - The `arb_state_t` enum {IDLE, GRANT0, GRANT1}.
- Sub-module `sam_tag_fifo`: 1-bit wide, TAG_DEPTH deep, with full/empty flags. Writes while full are ignored.

## Test plan
- Single requester: s0 sends {00,5,FEED}, then {01,5,0}. Expected: `m_*` carries both beats. When the memory returns a response, it appears only on `d0`; `d1_valid` stays 0 throughout.
- Contention: s0 and s1 both valid from reset with single-beat stores. Expected grant order is 0,1,0,1, with one accepted beat every 2 cycles.
- Atomicity: s0 sends a 3-beat packet with s1 valid throughout. Expected: `s1_ready` = 0 until s0's last beat is accepted; s1 is granted 2 cycles later.
- Ordering: s1 loads addr 20, then s0 loads addr 5. Expected: the first response goes to `d1` and the second to `d0`. Holding `d1_ready` = 0 holds `r_ready` = 0.
- Tag full: 8 loads are issued with the memory's `out_valid` held low. Expected: the 9th load stalls with `m_valid` = 0. It is accepted the cycle after the first response beat with last pops a tag.
- Orphan: `r_valid` = 1 with the FIFO empty. Expected: `r_ready` = 1, `orphan` pulses for 1 cycle, and both d_valid = 0.
